ctrl_pipe_regs: RTL and testbench
=================================

Name: ctrl_pipe_regs

Overview:
Consumer end of the decode control bundles (WB[1:0], M[2:0], EX[3:0]). Carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers, and splits them into per-stage control strobes. Decodes ALUOp plus funct into the 4-bit ALU control word in EX. Resolves branch PCSrc in MEM and squashes younger stages on taken branch, decode flush or load-use stall.

Parameters:
CNT_W, 16, width of saturating squash counter
ILLEGAL_ALU, 4'b1111, ALU control emitted for unsupported funct

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
id_wb  input  2  [1]=RegWrite, [0]=MemtoReg
id_m  input  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
id_ex  input  4  [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc
id_funct  input  6  instruction[5:0] of ID instruction
id_valid  input  1  ID holds a real instruction
id_flush  input  1  decode flush (jump); ID/EX loads bubble
stall  input  1  load-use stall; ID/EX loads bubble, older stages advance
mem_zero  input  1  ALU zero flag registered in EX/MEM datapath
ex_regdst, ex_alusrc  output  1 each  EX-stage strobes
ex_alu_ctrl  output  4  ALU operation select
ex_illegal  output  1  ALUOp=10 with unsupported funct, qualified by ex_valid
ex_valid  output  1
mem_branch, mem_memread, mem_memwrite, mem_valid  output  1 each
pcsrc  output  1  mem_branch & mem_zero & mem_valid (combinational)
wb_regwrite, wb_memtoreg, wb_valid  output  1 each
squash_cnt  output  CNT_W  cycles in which pcsrc was 1, saturating

Behaviour:
- Reset (async, rst=1): all stage registers, all outputs and squash_cnt go to 0 immediately. A bubble is all-zero control with valid=0.
- Stage registers hold wb/m/ex/funct/valid. Latency: ID values sampled at edge k appear at EX outputs after edge k, at MEM after k+1, and at WB after k+2.
- The ID/EX load priority at each edge is: pcsrc=1 → bubble; else id_flush|stall → bubble; else id_valid=0 → bubble; else the id_* fields.
- The EX/MEM load priority is: pcsrc=1 → bubble; else the ID/EX contents (the WB and M fields only).
- MEM/WB always loads the EX/MEM WB fields and valid. A taken branch retires normally; its WB bits are already 0.
- stall does not freeze EX/MEM or MEM/WB; it only inserts a bubble. The IF/ID hold is owned elsewhere.
- Every stage strobe output is the stored bit ANDed with that stage's valid. A bubble therefore drives 0 on all strobes.
- ALU control comes combinationally from the ID/EX ALUOp and funct fields:
  - ALUOp=00 → 0010 (add).
  - ALUOp=01 → 0110 (sub).
  - ALUOp=11 → 0010.
  - ALUOp=10 decodes funct: 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111. Any other funct → ILLEGAL_ALU, and ex_illegal=1.
  - When ex_valid=0, ex_alu_ctrl=0000 and ex_illegal=0.
- pcsrc is purely combinational from the EX/MEM state and mem_zero; it has no registered delay.
- squash_cnt increments by 1 on each edge where pcsrc=1. It holds at all-ones (no wrap).
- Simultaneous pcsrc and stall: pcsrc wins, and both younger stages are bubbled.
- Reset asserted mid-stream: in-flight instructions are discarded and nothing retires after rst deasserts until new id_valid input arrives.

Test Plan:
- R-type add: the inputs below give ex_alu_ctrl=0010 and ex_regdst=1 one cycle later, and wb_regwrite=1, wb_memtoreg=0 three cycles later.
  - Reset, then id_wb=10, id_m=000, id_ex=1100, id_funct=100000, id_valid=1 for one cycle.
- lw then sw: id_wb=11/m=010/ex=0001, then wb=00/m=001/ex=0001.
  - mem_memread=1 at edge+2, and mem_memwrite=1 at edge+3.
  - Only the lw gives wb_regwrite=1 and wb_memtoreg=1.
- Taken beq: beq (m=100, ex=0010), followed by two R-types.
  - With mem_zero=1, pcsrc=1 in the beq's MEM cycle and the two R-types never reach MEM/WB (wb_valid stays 0 for them).
  - squash_cnt=1.
  - With mem_zero=0, both R-types retire.
- stall=1 for one cycle during a valid lw: ex_valid=0 in the following cycle while the older lw still advances into MEM. stall together with pcsrc=1: both stages bubble.
- Illegal funct: id_ex=1100, funct=000111 → ex_alu_ctrl=1111 and ex_illegal=1. Same with id_valid=0 → ex_alu_ctrl=0000 and ex_illegal=0.
- Async reset: assert rst between clock edges with all three stages full → all outputs 0 before the next edge. Force squash_cnt to all-ones via repeated taken branches with CNT_W=2 → it holds at 3.

Source files
------------

// File: rtl/ctrl_pipe_regs.sv
// Control-path pipeline registers (ID/EX, EX/MEM, MEM/WB) with per-stage strobes,
// EX-stage ALU control decode, MEM-stage branch resolution and a saturating squash counter.
module ctrl_pipe_regs #(
    parameter int          CNT_W       = 16,
    parameter logic [3:0]  ILLEGAL_ALU = 4'b1111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       id_wb,
    input  logic [2:0]       id_m,
    input  logic [3:0]       id_ex,
    input  logic [5:0]       id_funct,
    input  logic             id_valid,
    input  logic             id_flush,
    input  logic             stall,
    input  logic             mem_zero,
    output logic             ex_regdst,
    output logic             ex_alusrc,
    output logic [3:0]       ex_alu_ctrl,
    output logic             ex_illegal,
    output logic             ex_valid,
    output logic             mem_branch,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             mem_valid,
    output logic             pcsrc,
    output logic             wb_regwrite,
    output logic             wb_memtoreg,
    output logic             wb_valid,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       ex_wb_q, ex_wb_d;
    logic [2:0]       ex_m_q, ex_m_d;
    logic [3:0]       ex_ex_q, ex_ex_d;
    logic [5:0]       ex_funct_q, ex_funct_d;
    logic             ex_valid_q, ex_valid_d;
    logic [1:0]       mem_wb_q, mem_wb_d;
    logic [2:0]       mem_m_q, mem_m_d;
    logic             mem_valid_q, mem_valid_d;
    logic [1:0]       wb_wb_q, wb_wb_d;
    logic             wb_valid_q, wb_valid_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
    logic             pcsrc_s;
    logic [3:0]       alu_ctrl_s;
    logic             illegal_s;

    assign pcsrc_s = mem_m_q[2] & mem_valid_q & mem_zero;

    // ID/EX next state: a taken branch outranks flush/stall, which outrank an empty ID slot
    always_comb begin
        ex_wb_d    = 2'b00;
        ex_m_d     = 3'b000;
        ex_ex_d    = 4'b0000;
        ex_funct_d = 6'b000000;
        ex_valid_d = 1'b0;
        if (pcsrc_s) begin
            ex_valid_d = 1'b0;
        end else if (id_flush || stall) begin
            ex_valid_d = 1'b0;
        end else if (!id_valid) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_wb_d    = id_wb;
            ex_m_d     = id_m;
            ex_ex_d    = id_ex;
            ex_funct_d = id_funct;
            ex_valid_d = 1'b1;
        end
    end

    // EX/MEM and MEM/WB next state; the taken branch itself still retires with zero WB bits
    always_comb begin
        mem_wb_d    = 2'b00;
        mem_m_d     = 3'b000;
        mem_valid_d = 1'b0;
        if (pcsrc_s) begin
            mem_valid_d = 1'b0;
        end else begin
            mem_wb_d    = ex_wb_q;
            mem_m_d     = ex_m_q;
            mem_valid_d = ex_valid_q;
        end
        wb_wb_d    = mem_wb_q;
        wb_valid_d = mem_valid_q;
    end

    // Saturating count of branch-squash cycles
    always_comb begin
        squash_cnt_d = squash_cnt_q;
        if (pcsrc_s && (squash_cnt_q != CNT_MAX)) begin
            squash_cnt_d = squash_cnt_q + CNT_ONE;
        end else begin
            squash_cnt_d = squash_cnt_q;
        end
    end

    // ALU control decode from the ID/EX ALUOp and funct fields, gated by EX valid
    always_comb begin
        alu_ctrl_s = 4'b0000;
        illegal_s  = 1'b0;
        if (ex_valid_q) begin
            case (ex_ex_q[2:1])
                2'b00:   alu_ctrl_s = 4'b0010;
                2'b01:   alu_ctrl_s = 4'b0110;
                2'b11:   alu_ctrl_s = 4'b0010;
                2'b10: begin
                    case (ex_funct_q)
                        6'b100000: alu_ctrl_s = 4'b0010;
                        6'b100010: alu_ctrl_s = 4'b0110;
                        6'b100100: alu_ctrl_s = 4'b0000;
                        6'b100101: alu_ctrl_s = 4'b0001;
                        6'b101010: alu_ctrl_s = 4'b0111;
                        default: begin
                            alu_ctrl_s = ILLEGAL_ALU;
                            illegal_s  = 1'b1;
                        end
                    endcase
                end
                default: alu_ctrl_s = 4'b0000;
            endcase
        end else begin
            alu_ctrl_s = 4'b0000;
            illegal_s  = 1'b0;
        end
    end

    // Stage registers and squash counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_wb_q      <= 2'b00;
            ex_m_q       <= 3'b000;
            ex_ex_q      <= 4'b0000;
            ex_funct_q   <= 6'b000000;
            ex_valid_q   <= 1'b0;
            mem_wb_q     <= 2'b00;
            mem_m_q      <= 3'b000;
            mem_valid_q  <= 1'b0;
            wb_wb_q      <= 2'b00;
            wb_valid_q   <= 1'b0;
            squash_cnt_q <= '0;
        end else begin
            ex_wb_q      <= ex_wb_d;
            ex_m_q       <= ex_m_d;
            ex_ex_q      <= ex_ex_d;
            ex_funct_q   <= ex_funct_d;
            ex_valid_q   <= ex_valid_d;
            mem_wb_q     <= mem_wb_d;
            mem_m_q      <= mem_m_d;
            mem_valid_q  <= mem_valid_d;
            wb_wb_q      <= wb_wb_d;
            wb_valid_q   <= wb_valid_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign ex_regdst    = ex_ex_q[3] & ex_valid_q;
    assign ex_alusrc    = ex_ex_q[0] & ex_valid_q;
    assign ex_alu_ctrl  = alu_ctrl_s;
    assign ex_illegal   = illegal_s;
    assign ex_valid     = ex_valid_q;
    assign mem_branch   = mem_m_q[2] & mem_valid_q;
    assign mem_memread  = mem_m_q[1] & mem_valid_q;
    assign mem_memwrite = mem_m_q[0] & mem_valid_q;
    assign mem_valid    = mem_valid_q;
    assign pcsrc        = pcsrc_s;
    assign wb_regwrite  = wb_wb_q[1] & wb_valid_q;
    assign wb_memtoreg  = wb_wb_q[0] & wb_valid_q;
    assign wb_valid     = wb_valid_q;
    assign squash_cnt   = squash_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed self-checking bench for ctrl_pipe_regs; a second instance with CNT_W=2
// shares all inputs and is used for the squash counter saturation check.
module tb_ctrl_pipe_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  id_wb = 2'b00;
    logic [2:0]  id_m = 3'b000;
    logic [3:0]  id_ex = 4'b0000;
    logic [5:0]  id_funct = 6'b000000;
    logic        id_valid = 1'b0, id_flush = 1'b0, stall = 1'b0, mem_zero = 1'b0;
    logic        ex_regdst, ex_alusrc, ex_illegal, ex_valid;
    logic [3:0]  ex_alu_ctrl;
    logic        mem_branch, mem_memread, mem_memwrite, mem_valid, pcsrc;
    logic        wb_regwrite, wb_memtoreg, wb_valid;
    logic [15:0] squash_cnt;
    logic        b_regdst, b_alusrc, b_illegal, b_ex_valid, b_branch, b_memread, b_memwrite;
    logic        b_mem_valid, b_pcsrc, b_regwrite, b_memtoreg, b_wb_valid;
    logic [3:0]  b_alu_ctrl;
    logic [1:0]  b_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ctrl_pipe_regs u_dut (
        .clk(clk), .rst(rst), .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex), .id_funct(id_funct),
        .id_valid(id_valid), .id_flush(id_flush), .stall(stall), .mem_zero(mem_zero),
        .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_illegal(ex_illegal), .ex_valid(ex_valid), .mem_branch(mem_branch),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_valid(mem_valid),
        .pcsrc(pcsrc), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_valid(wb_valid), .squash_cnt(squash_cnt)
    );

    ctrl_pipe_regs #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex), .id_funct(id_funct),
        .id_valid(id_valid), .id_flush(id_flush), .stall(stall), .mem_zero(mem_zero),
        .ex_regdst(b_regdst), .ex_alusrc(b_alusrc), .ex_alu_ctrl(b_alu_ctrl),
        .ex_illegal(b_illegal), .ex_valid(b_ex_valid), .mem_branch(b_branch),
        .mem_memread(b_memread), .mem_memwrite(b_memwrite), .mem_valid(b_mem_valid),
        .pcsrc(b_pcsrc), .wb_regwrite(b_regwrite), .wb_memtoreg(b_memtoreg),
        .wb_valid(b_wb_valid), .squash_cnt(b_cnt)
    );

    function automatic logic [13:0] all_outs();
        return {ex_regdst, ex_alusrc, ex_alu_ctrl, ex_illegal, ex_valid, mem_branch,
                mem_memread, mem_memwrite, mem_valid, pcsrc, wb_regwrite};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                         input logic [5:0] fn, input logic v);
        id_wb = wb; id_m = m; id_ex = ex; id_funct = fn; id_valid = v;
    endtask

    task automatic bubble();
        drive(2'b00, 3'b000, 4'b0000, 6'b000000, 1'b0);
    endtask

    task automatic do_reset();
        bubble();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({all_outs(), wb_memtoreg, wb_valid} !== 16'h0000) begin
            n_bad++; $display("FAIL reset_outs: got %h want 0000", {all_outs(), wb_memtoreg, wb_valid});
        end
        n_cmp++;
        if (squash_cnt !== 16'h0000) begin
            n_bad++; $display("FAIL reset_cnt: got %h want 0000", squash_cnt);
        end
    endtask

    task automatic test_rtype_add();
        drive(2'b10, 3'b000, 4'b1100, 6'b100000, 1'b1);
        step();
        bubble();
        n_cmp++;
        if ({ex_alu_ctrl, ex_regdst, ex_alusrc, ex_valid} !== 7'b0010_101) begin
            n_bad++; $display("FAIL add_ex: got %b want 0010101", {ex_alu_ctrl, ex_regdst, ex_alusrc, ex_valid});
        end
        step();
        n_cmp++;
        if ({ex_valid, mem_valid, wb_valid} !== 3'b010) begin
            n_bad++; $display("FAIL add_mem: got %b want 010", {ex_valid, mem_valid, wb_valid});
        end
        step();
        n_cmp++;
        if ({wb_regwrite, wb_memtoreg, wb_valid} !== 3'b101) begin
            n_bad++; $display("FAIL add_wb: got %b want 101", {wb_regwrite, wb_memtoreg, wb_valid});
        end
        step();
    endtask

    task automatic test_lw_sw();
        drive(2'b11, 3'b010, 4'b0001, 6'b000000, 1'b1);
        step();
        n_cmp++;
        if ({ex_alu_ctrl, ex_alusrc, ex_regdst} !== 6'b0010_10) begin
            n_bad++; $display("FAIL lw_ex: got %b want 001010", {ex_alu_ctrl, ex_alusrc, ex_regdst});
        end
        drive(2'b00, 3'b001, 4'b0001, 6'b000000, 1'b1);
        step();
        bubble();
        n_cmp++;
        if ({mem_memread, mem_memwrite, mem_branch} !== 3'b100) begin
            n_bad++; $display("FAIL lw_mem: got %b want 100", {mem_memread, mem_memwrite, mem_branch});
        end
        step();
        n_cmp++;
        if ({mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg} !== 4'b0111) begin
            n_bad++; $display("FAIL sw_mem_lw_wb: got %b want 0111", {mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg});
        end
        step();
        n_cmp++;
        if ({wb_regwrite, wb_memtoreg, wb_valid} !== 3'b001) begin
            n_bad++; $display("FAIL sw_wb: got %b want 001", {wb_regwrite, wb_memtoreg, wb_valid});
        end
        step();
    endtask

    task automatic test_branch_taken();
        do_reset();
        mem_zero = 1'b1;
        drive(2'b00, 3'b100, 4'b0010, 6'b000000, 1'b1);
        step();
        n_cmp++;
        if ({ex_alu_ctrl, pcsrc} !== 5'b0110_0) begin
            n_bad++; $display("FAIL beq_ex: got %b want 01100", {ex_alu_ctrl, pcsrc});
        end
        drive(2'b10, 3'b000, 4'b1100, 6'b100000, 1'b1);
        step();
        n_cmp++;
        if ({pcsrc, mem_branch, ex_valid, squash_cnt} !== {3'b111, 16'd0}) begin
            n_bad++; $display("FAIL beq_pcsrc: got %b want 111 cnt 0", {pcsrc, mem_branch, ex_valid, squash_cnt});
        end
        drive(2'b10, 3'b000, 4'b1100, 6'b100010, 1'b1);
        step();
        bubble();
        n_cmp++;
        if ({ex_valid, mem_valid, wb_valid, wb_regwrite, pcsrc} !== 5'b00100 || squash_cnt !== 16'd1) begin
            n_bad++; $display("FAIL beq_squash: got %b cnt %0d want 00100 cnt 1", {ex_valid, mem_valid, wb_valid, wb_regwrite, pcsrc}, squash_cnt);
        end
        step();
        n_cmp++;
        if ({wb_valid, mem_valid} !== 2'b00) begin
            n_bad++; $display("FAIL beq_r1_gone: got %b want 00", {wb_valid, mem_valid});
        end
        step();
        n_cmp++;
        if ({wb_valid, squash_cnt} !== {1'b0, 16'd1}) begin
            n_bad++; $display("FAIL beq_r2_gone: got %b want 0 cnt 1", {wb_valid, squash_cnt});
        end
    endtask

    task automatic test_branch_not_taken();
        mem_zero = 1'b0;
        drive(2'b00, 3'b100, 4'b0010, 6'b000000, 1'b1);
        step();
        drive(2'b10, 3'b000, 4'b1100, 6'b100000, 1'b1);
        step();
        n_cmp++;
        if (pcsrc !== 1'b0) begin
            n_bad++; $display("FAIL nt_pcsrc: got %b want 0", pcsrc);
        end
        drive(2'b10, 3'b000, 4'b1100, 6'b100010, 1'b1);
        step();
        bubble();
        step();
        n_cmp++;
        if ({wb_regwrite, wb_valid} !== 2'b11) begin
            n_bad++; $display("FAIL nt_r1_wb: got %b want 11", {wb_regwrite, wb_valid});
        end
        step();
        n_cmp++;
        if ({wb_regwrite, wb_valid, squash_cnt} !== {2'b11, 16'd1}) begin
            n_bad++; $display("FAIL nt_r2_wb: got %b want 11 cnt 1", {wb_regwrite, wb_valid, squash_cnt});
        end
        step();
    endtask

    task automatic test_stall();
        do_reset();
        drive(2'b11, 3'b010, 4'b0001, 6'b000000, 1'b1);
        step();
        drive(2'b10, 3'b000, 4'b1100, 6'b100000, 1'b1);
        stall = 1'b1;
        step();
        stall = 1'b0;
        bubble();
        n_cmp++;
        if ({ex_valid, mem_valid, mem_memread} !== 3'b011) begin
            n_bad++; $display("FAIL stall_bubble: got %b want 011", {ex_valid, mem_valid, mem_memread});
        end
        step();
        step();
        step();
        mem_zero = 1'b1;
        drive(2'b00, 3'b100, 4'b0010, 6'b000000, 1'b1);
        step();
        drive(2'b10, 3'b000, 4'b1100, 6'b100000, 1'b1);
        step();
        drive(2'b10, 3'b000, 4'b1100, 6'b100010, 1'b1);
        stall = 1'b1;
        step();
        stall = 1'b0;
        bubble();
        n_cmp++;
        if ({ex_valid, mem_valid, wb_valid} !== 3'b001) begin
            n_bad++; $display("FAIL stall_pcsrc: got %b want 001", {ex_valid, mem_valid, wb_valid});
        end
        mem_zero = 1'b0;
        step();
        step();
    endtask

    task automatic test_alu_decode();
        logic [1:0] ops  [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
        logic [5:0] fns  [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111, 6'b000111, 6'b000000};
        logic [4:0] exps [8] = '{5'b0010_0, 5'b0110_0, 5'b0000_0, 5'b0001_0, 5'b0111_0, 5'b1111_1, 5'b0010_0, 5'b0110_0};
        for (int i = 0; i < 8; i++) begin
            drive(2'b10, 3'b000, {1'b1, ops[i], 1'b0}, fns[i], 1'b1);
            step();
            n_cmp++;
            if ({ex_alu_ctrl, ex_illegal} !== exps[i]) begin
                n_bad++; $display("FAIL alu_dec[%0d]: got %b want %b", i, {ex_alu_ctrl, ex_illegal}, exps[i]);
            end
        end
        drive(2'b10, 3'b000, 4'b1100, 6'b000111, 1'b0);
        step();
        n_cmp++;
        if ({ex_alu_ctrl, ex_illegal} !== 5'b0000_0) begin
            n_bad++; $display("FAIL alu_invalid: got %b want 00000", {ex_alu_ctrl, ex_illegal});
        end
        drive(2'b10, 3'b000, 4'b1100, 6'b100000, 1'b1);
        id_flush = 1'b1;
        step();
        id_flush = 1'b0;
        bubble();
        n_cmp++;
        if ({ex_valid, ex_alu_ctrl} !== 5'b0_0000) begin
            n_bad++; $display("FAIL flush: got %b want 00000", {ex_valid, ex_alu_ctrl});
        end
        step();
        step();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 3'b010, 4'b1001, 6'b100000, 1'b1);
            step();
        end
        n_cmp++;
        if ({ex_valid, mem_valid, wb_valid} !== 3'b111) begin
            n_bad++; $display("FAIL full_pipe: got %b want 111", {ex_valid, mem_valid, wb_valid});
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({all_outs(), wb_memtoreg, wb_valid, squash_cnt} !== 32'h0) begin
            n_bad++; $display("FAIL async_rst: got %h want 0", {all_outs(), wb_memtoreg, wb_valid, squash_cnt});
        end
        bubble();
        step();
        rst = 1'b0;
        step();
        step();
        n_cmp++;
        if ({ex_valid, mem_valid, wb_valid, wb_regwrite} !== 4'b0000) begin
            n_bad++; $display("FAIL post_rst_retire: got %b want 0000", {ex_valid, mem_valid, wb_valid, wb_regwrite});
        end
    endtask

    task automatic test_saturate();
        do_reset();
        mem_zero = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(2'b00, 3'b100, 4'b0010, 6'b000000, 1'b1);
            step();
            bubble();
            step();
            step();
            n_cmp++;
            if (b_cnt !== ((i > 3) ? 2'd3 : 2'(i)) || squash_cnt !== 16'(i)) begin
                n_bad++; $display("FAIL sat[%0d]: got %0d/%0d want %0d/%0d", i, b_cnt, squash_cnt, (i > 3) ? 3 : i, i);
            end
        end
        mem_zero = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_lw_sw();
        test_branch_taken();
        test_branch_not_taken();
        test_stall();
        test_alu_decode();
        test_async_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
